tx_pcs_scrambler_32b: RTL and testbench

- 10GBASE-R transmit stage directly upstream of the 32-bit TX gearbox.
- Accepts 66-bit encoded blocks (2-bit sync header plus 64-bit payload) from the 64b/66b encoder over a valid/ready handshake.
- Scrambles each payload with the self-synchronous x^58+x^39+1 scrambler and emits two 32-bit words per block, with the header, word-enable and even flag.
- Output pacing is the fixed 33-cycle pattern the gearbox needs: 32 enabled words, then 1 pause. When the encoder has nothing ready at a block slot, the block inserts an idle block.

---
 rtl/pcs_10g_pkg.sv | 20 ++
 rtl/scrambler_58_step.sv | 33 +++
 rtl/tx_pcs_scrambler_32b.sv | 100 ++++++++++
 tb/tb_tx_pcs_scrambler_32b.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pcs_10g_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pcs_10g_pkg
//  Purpose  : Shared 10GBASE-R PCS constants and types (headers, idle block,
//             gearbox period, scrambler state).
//  Revision : 1.0
// ============================================================================
package pcs_10g_pkg;

    localparam logic [1:0]  HDR_DATA  = 2'b10;
    localparam logic [1:0]  HDR_CTRL  = 2'b01;
    localparam logic [63:0] IDLE_BLK  = 64'h0000_0000_0000_001E;
    localparam int          GB_PERIOD = 33;
    localparam int          SCR_W     = 58;
    localparam int          PHASE_W   = 6;

    typedef logic [SCR_W-1:0] scr_state_t;

endpackage
`default_nettype wire

// File: rtl/scrambler_58_step.sv
`default_nettype none
// ============================================================================
//  Module   : scrambler_58_step
//  Purpose  : Combinational 32-bit step of the x^58+x^39+1 self-synchronous
//             scrambler; bit 0 is processed first.
//  Revision : 1.0
// ============================================================================
module scrambler_58_step
    import pcs_10g_pkg::*;
(
    input  logic [31:0] data_in,
    input  scr_state_t  state_in,
    output logic [31:0] data_out,
    output scr_state_t  state_out
);

    always_comb begin : p_step
        scr_state_t s;
        logic       b;
        data_out = '0;
        s        = state_in;
        b        = 1'b0;
        // Newest bit lives in s[0], so taps 39 and 58 map to s[38] and s[57].
        for (int i = 0; i < 32; i++) begin
            b           = data_in[i] ^ s[38] ^ s[57];
            data_out[i] = b;
            s           = {s[SCR_W-2:0], b};
        end
        state_out = s;
    end

endmodule
`default_nettype wire

// File: rtl/tx_pcs_scrambler_32b.sv
`default_nettype none
// ============================================================================
//  Module   : tx_pcs_scrambler_32b
//  Purpose  : 10GBASE-R TX scrambler feeding a 32-bit gearbox with the 32-on /
//             1-off pacing. Optional scr_bypass port: TX_SCRAMBLER_BYPASS_EN.
//  Revision : 1.0
// ============================================================================
module tx_pcs_scrambler_32b
    import pcs_10g_pkg::*;
#(
    parameter scr_state_t SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef TX_SCRAMBLER_BYPASS_EN
    input  logic        scr_bypass,
`endif
    input  logic [63:0] blk_data,
    input  logic [1:0]  blk_hdr,
    input  logic        blk_valid,
    output logic        blk_ready,
    output logic [31:0] dout,
    output logic [1:0]  ctrl,
    output logic        dout_en,
    output logic        even,
    output logic        idle_ins
);

    localparam logic [PHASE_W-1:0] c_pause_ph = PHASE_W'(GB_PERIOD - 1);

    logic [PHASE_W-1:0] phase_r;
    scr_state_t         scr_r;
    logic [31:0]        hold_r;

    logic               w_even_slot;
    logic               w_pause;
    logic [63:0]        w_src;
    logic [1:0]         w_src_hdr;
    logic [31:0]        w_word_in;
    logic [31:0]        w_word_scr;
    scr_state_t         w_scr_next;
    logic               w_bypass;

`ifdef TX_SCRAMBLER_BYPASS_EN
    assign w_bypass = scr_bypass;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pause     = (phase_r == c_pause_ph);
    assign w_even_slot = (phase_r < c_pause_ph) & ~phase_r[0];
    assign blk_ready   = w_even_slot;

    // An empty slot is filled with an idle control block so the gearbox never starves.
    assign w_src     = blk_valid ? blk_data : IDLE_BLK;
    assign w_src_hdr = blk_valid ? blk_hdr  : HDR_CTRL;
    assign w_word_in = w_even_slot ? w_src[31:0] : hold_r;

    scrambler_58_step u_step (
        .data_in   (w_word_in),
        .state_in  (scr_r),
        .data_out  (w_word_scr),
        .state_out (w_scr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r  <= '0;
            scr_r    <= SCR_SEED;
            hold_r   <= '0;
            dout     <= '0;
            ctrl     <= '0;
            dout_en  <= 1'b0;
            even     <= 1'b0;
            idle_ins <= 1'b0;
        end else begin
            phase_r <= w_pause ? '0 : phase_r + 1'b1;
            if (w_pause) begin
                dout_en  <= 1'b0;
                idle_ins <= 1'b0;
            end else begin
                // Bypass only selects the output; the state always follows the scrambled stream.
                dout    <= w_bypass ? w_word_in : w_word_scr;
                scr_r   <= w_scr_next;
                dout_en <= 1'b1;
                if (w_even_slot) begin
                    ctrl     <= w_src_hdr;
                    hold_r   <= w_src[63:32];
                    even     <= 1'b1;
                    idle_ins <= ~blk_valid;
                end else begin
                    even     <= 1'b0;
                    idle_ins <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_pcs_scrambler_32b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_pcs_scrambler_32b
//  Purpose  : Self-checking bench for tx_pcs_scrambler_32b against a bit-stream
//             scrambler model and hand-computed words.
//  Revision : 1.0
// ============================================================================
module tb_tx_pcs_scrambler_32b;
    import pcs_10g_pkg::*;

    localparam logic [57:0] c_seed = 58'h3FF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] blk_data = '0;
    logic [1:0]  blk_hdr = HDR_DATA;
    logic        blk_valid = 1'b0;
    logic        blk_ready;
    logic [31:0] dout;
    logic [1:0]  ctrl;
    logic        dout_en, even, idle_ins;

    logic        ready_z, en_z, even_z, idle_z;
    logic [31:0] dout_z;
    logic [1:0]  ctrl_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tx_pcs_scrambler_32b #(.SCR_SEED(c_seed)) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TX_SCRAMBLER_BYPASS_EN
        .scr_bypass(1'b0),
`endif
        .blk_data  (blk_data),
        .blk_hdr   (blk_hdr),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .dout      (dout),
        .ctrl      (ctrl),
        .dout_en   (dout_en),
        .even      (even),
        .idle_ins  (idle_ins)
    );

    tx_pcs_scrambler_32b #(.SCR_SEED(58'h0)) u_zero (
        .clk       (clk),
        .rst       (rst),
`ifdef TX_SCRAMBLER_BYPASS_EN
        .scr_bypass(1'b0),
`endif
        .blk_data  (64'h0),
        .blk_hdr   (HDR_DATA),
        .blk_valid (1'b1),
        .blk_ready (ready_z),
        .dout      (dout_z),
        .ctrl      (ctrl_z),
        .dout_en   (en_z),
        .even      (even_z),
        .idle_ins  (idle_z)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: transmitted bit history, oldest first ----------
    bit          hist[$];
    int          mph;
    bit          mvalid = 0;
    logic [31:0] e_dout, e_hold;
    logic [1:0]  e_ctrl;
    logic        e_en, e_even, e_idle;

    function automatic logic [31:0] scr_word(input logic [31:0] w);
        logic [31:0] r;
        bit b;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            b = w[i] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
            r[i] = b;
            hist.push_back(b);
            void'(hist.pop_front());
        end
        return r;
    endfunction

    always @(negedge clk) begin
        logic [63:0] src;
        if (mvalid) begin
            chk("blk_ready", blk_ready, (mph < 32 && mph % 2 == 0));
            chk("dout_en",   dout_en,   e_en);
            chk("even",      even,      e_even);
            chk("idle_ins",  idle_ins,  e_idle);
            chk("ctrl",      ctrl,      e_ctrl);
            chk("dout",      dout,      e_dout);
            chk("zero_dout", dout_z,    32'h0);
            if (even_z) chk("zero_ctrl", ctrl_z, HDR_DATA);
        end
        if (rst) begin
            hist.delete();
            for (int k = 57; k >= 0; k--) hist.push_back(c_seed[k]);
            mph = 0; mvalid = 1;
            e_dout = '0; e_hold = '0; e_ctrl = '0;
            e_en = 0; e_even = 0; e_idle = 0;
        end else if (mvalid) begin
            if (mph == 32) begin
                e_en = 0; e_idle = 0;
            end else if (mph % 2 == 0) begin
                src    = blk_valid ? blk_data : IDLE_BLK;
                e_ctrl = blk_valid ? blk_hdr : HDR_CTRL;
                e_dout = scr_word(src[31:0]);
                e_hold = src[63:32];
                e_en = 1; e_even = 1; e_idle = !blk_valid;
            end else begin
                e_dout = scr_word(e_hold);
                e_en = 1; e_even = 0; e_idle = 0;
            end
            mph = (mph + 1) % GB_PERIOD;
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic first_words_after_reset(input string tag);
        @(posedge clk); #1;
        chk({tag, "_w0_dout"}, dout, 32'h0000_001E);
        chk({tag, "_w0_ctrl"}, ctrl, HDR_CTRL);
        chk({tag, "_w0_idle"}, idle_ins, 1'b1);
        chk({tag, "_w0_even"}, even, 1'b1);
        @(posedge clk); #1;
        chk({tag, "_w1_dout"}, dout, 32'h7BFF_F080);
        chk({tag, "_w1_even"}, even, 1'b0);
    endtask

    initial begin
        int n_idle, n_en, acc, cyc;
        bit fire, found;

        rst = 1; blk_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 32'h0);
        chk("rst_ctrl", ctrl, 2'b00);
        chk("rst_en",   dout_en, 1'b0);
        chk("rst_even", even, 1'b0);
        chk("rst_idle", idle_ins, 1'b0);
        rst = 0;

        first_words_after_reset("seed");

        n_idle = 0; n_en = 0;
        repeat (GB_PERIOD) begin
            @(posedge clk); #1;
            n_idle += int'(idle_ins);
            n_en   += int'(dout_en);
        end
        chk("idle_per_period", 64'(n_idle), 64'd16);
        chk("en_per_period",   64'(n_en),   64'd32);
        repeat (40) @(posedge clk);

        // random blocks with occasional gaps
        #1;
        blk_data  = {$urandom, $urandom};
        blk_hdr   = $urandom_range(0, 1) ? HDR_DATA : HDR_CTRL;
        blk_valid = 1;
        acc = 0; cyc = 0;
        while (acc < 1000 && cyc < 4000) begin
            @(negedge clk);
            fire = blk_ready & blk_valid;
            @(posedge clk); #1;
            cyc++;
            if (fire) acc++;
            if (fire || !blk_valid) begin
                blk_data  = {$urandom, $urandom};
                blk_hdr   = $urandom_range(0, 1) ? HDR_DATA : HDR_CTRL;
                blk_valid = ($urandom_range(0, 7) != 0);
            end
        end
        chk("blocks_accepted", 64'(acc), 64'd1000);

        // reset in the middle of a block
        blk_valid = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (mph == 4) found = 1;
        end
        chk("found_phase4", 64'(found), 64'd1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("mid_rst_dout", dout, 32'h0);
        chk("mid_rst_ctrl", ctrl, 2'b00);
        chk("mid_rst_en",   dout_en, 1'b0);
        chk("mid_rst_even", even, 1'b0);
        rst = 0;
        first_words_after_reset("rerst");
        repeat (70) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
